fetch_axi_line_reader: RTL and testbench

// - AXI-domain fetch engine: takes instruction line-fill requests and issues one AXI4 INCR read burst per line.
// - Streams each returned R beat into the write side of the fetch CDC FIFO (wr_en/wr_data/wr_full).
// - The FIFO carries the line to the cpu_clk domain. At most one burst is outstanding.
// - Supports flush: the in-flight burst is drained from AXI and discarded.

---
 rtl/fetch_axi_line_reader.sv | 81 ++++++++
 tb/tb_fetch_axi_line_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_axi_line_reader.sv
// fetch_axi_line_reader: one AXI4 INCR read burst per line fill, streamed into a CDC FIFO write port (req in, AR/R out, wr_* push, busy/proto_err status)
module fetch_axi_line_reader #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic              axi_clk,
  input  logic              axi_resetn,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  input  logic              flush_i,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_err_o,
  output logic              wr_last_o,
  input  logic              wr_full_i,
  output logic              busy_o,
  output logic              proto_err_o
);
  localparam int OFS = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int CW = $clog2(LINE_BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFS;
  typedef enum logic [1:0] {IDLE, ADDR, STREAM, DRAIN} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic flush_seen, r_hs, at_end, accept;
  assign r_hs = rvalid_i & rready_o;
  assign at_end = cnt == CW'(LINE_BEATS - 1);
  assign accept = req_valid_i & req_ready_o;
  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state <= IDLE;
      araddr_o <= '0;
      cnt <= '0;
      flush_seen <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) araddr_o <= req_addr_i & LINE_MASK;
      // a flush during a stalled AR is remembered so the burst is drained once accepted
      flush_seen <= (state == ADDR) & ~arready_i & (flush_seen | flush_i);
      if (r_hs) cnt <= rlast_i ? '0 : cnt + CW'(1);
      // rlast must coincide exactly with the final beat index
      if (r_hs & (rlast_i != at_end)) proto_err_o <= 1'b1;
    end
  end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   state_d = accept ? ADDR : IDLE;
      ADDR:   state_d = arready_i ? ((flush_i | flush_seen) ? DRAIN : STREAM) : ADDR;
      STREAM: state_d = (r_hs & rlast_i) ? IDLE : (flush_i | (r_hs & at_end)) ? DRAIN : STREAM;
      DRAIN:  state_d = (r_hs & rlast_i) ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    req_ready_o = axi_resetn & (state == IDLE);
    arvalid_o = state == ADDR;
    rready_o = ((state == STREAM) & ~wr_full_i) | (state == DRAIN);
    wr_en_o = (state == STREAM) & rvalid_i & ~wr_full_i & ~flush_i;
    busy_o = state != IDLE;
    arlen_o = arvalid_o ? 8'(LINE_BEATS - 1) : '0;
    arsize_o = arvalid_o ? 3'($clog2(DATA_W / 8)) : '0;
    arburst_o = arvalid_o ? 2'b01 : '0;
    wr_data_o = wr_en_o ? rdata_i : '0;
    wr_err_o = wr_en_o & (rresp_i != 2'b00);
    wr_last_o = wr_en_o & rlast_i;
  end
endmodule

// File: tb/tb_fetch_axi_line_reader.sv
// tb_fetch_axi_line_reader: directed scenarios for the AXI line reader
module tb_fetch_axi_line_reader;
  logic        axi_clk = 1'b0;
  logic        axi_resetn = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [63:0] req_addr_i = '0;
  logic        req_ready_o;
  logic        flush_i = 1'b0;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [63:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [63:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        rlast_i = 1'b0;
  logic        wr_en_o;
  logic [63:0] wr_data_o;
  logic        wr_err_o;
  logic        wr_last_o;
  logic        wr_full_i = 1'b0;
  logic        busy_o;
  logic        proto_err_o;
  int checks = 0;
  int errors = 0;

  fetch_axi_line_reader dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .flush_i(flush_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
    .rresp_i(rresp_i), .rlast_i(rlast_i),
    .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .wr_err_o(wr_err_o),
    .wr_last_o(wr_last_o), .wr_full_i(wr_full_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic [63:0] a);
    req_valid_i = 1'b1;
    req_addr_i = a;
    @(negedge axi_clk);
    req_valid_i = 1'b0;
  endtask

  task automatic ar_handshake;
    arready_i = 1'b1;
    @(negedge axi_clk);
    arready_i = 1'b0;
  endtask

  task automatic test_reset;
    axi_resetn = 1'b0;
    repeat (2) @(negedge axi_clk);
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b exp 0", arvalid_o); end
    checks++; if (araddr_o !== 64'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", araddr_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err_o); end
    checks++; if (rready_o !== 1'b0) begin errors++; $display("FAIL reset_rready got %b exp 0", rready_o); end
    axi_resetn = 1'b1;
    @(negedge axi_clk);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_req_ready got %b exp 1", req_ready_o); end
  endtask

  task automatic test_basic;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL basic_req_ready got %b exp 1", req_ready_o); end
    issue(64'h1234);
    #1;
    checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL basic_arvalid got %b exp 1", arvalid_o); end
    checks++; if (araddr_o !== 64'h1220) begin errors++; $display("FAIL basic_araddr got %h exp 1220", araddr_o); end
    checks++; if (arlen_o !== 8'd3) begin errors++; $display("FAIL basic_arlen got %0d exp 3", arlen_o); end
    checks++; if (arsize_o !== 3'd3) begin errors++; $display("FAIL basic_arsize got %0d exp 3", arsize_o); end
    checks++; if (arburst_o !== 2'b01) begin errors++; $display("FAIL basic_arburst got %b exp 01", arburst_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL basic_req_ready_busy got %b exp 0", req_ready_o); end
    ar_handshake;
    for (int b = 0; b < 4; b++) begin
      rvalid_i = 1'b1;
      rdata_i = 64'hA0 + 64'(b);
      rlast_i = (b == 3);
      #1;
      checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL basic_wr_en beat %0d got %b exp 1", b, wr_en_o); end
      checks++; if (wr_data_o !== 64'hA0 + 64'(b)) begin errors++; $display("FAIL basic_wr_data beat %0d got %h exp %h", b, wr_data_o, 64'hA0 + 64'(b)); end
      checks++; if (wr_last_o !== (b == 3)) begin errors++; $display("FAIL basic_wr_last beat %0d got %b exp %b", b, wr_last_o, b == 3); end
      @(negedge axi_clk);
    end
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL basic_idle_req_ready got %b exp 1", req_ready_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL basic_proto_err got %b exp 0", proto_err_o); end
  endtask

  task automatic test_backpressure;
    int idx [6] = '{0, 1, 1, 1, 2, 3};
    logic full [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int n = 0;
    issue(64'h2000);
    ar_handshake;
    for (int c = 0; c < 6; c++) begin
      rvalid_i = 1'b1;
      rdata_i = 64'hB0 + 64'(idx[c]);
      rlast_i = (idx[c] == 3);
      wr_full_i = full[c];
      #1;
      checks++; if (rready_o !== !full[c]) begin errors++; $display("FAIL bp_rready cycle %0d got %b exp %b", c, rready_o, !full[c]); end
      checks++; if (wr_en_o !== !full[c]) begin errors++; $display("FAIL bp_wr_en cycle %0d got %b exp %b", c, wr_en_o, !full[c]); end
      if (wr_en_o === 1'b1) begin
        checks++; if (wr_data_o !== 64'hB0 + 64'(n)) begin errors++; $display("FAIL bp_order push %0d got %h exp %h", n, wr_data_o, 64'hB0 + 64'(n)); end
        n++;
      end
      @(negedge axi_clk);
    end
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    wr_full_i = 1'b0;
    #1;
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_push_count got %0d exp 4", n); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", busy_o); end
  endtask

  task automatic test_flush_addr;
    int pushes = 0;
    issue(64'h4010);
    flush_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL fa_arvalid cycle %0d got %b exp 1", c, arvalid_o); end
      checks++; if (araddr_o !== 64'h4000) begin errors++; $display("FAIL fa_araddr cycle %0d got %h exp 4000", c, araddr_o); end
      @(negedge axi_clk);
      flush_i = 1'b0;
    end
    ar_handshake;
    for (int b = 0; b < 4; b++) begin
      rvalid_i = 1'b1;
      rdata_i = 64'hC0 + 64'(b);
      rlast_i = (b == 3);
      #1;
      checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL fa_rready beat %0d got %b exp 1", b, rready_o); end
      if (wr_en_o === 1'b1) pushes++;
      @(negedge axi_clk);
    end
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    #1;
    checks++; if (pushes !== 0) begin errors++; $display("FAIL fa_pushes got %0d exp 0", pushes); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fa_idle got %b exp 0", busy_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL fa_req_ready got %b exp 1", req_ready_o); end
  endtask

  task automatic test_flush_stream;
    issue(64'h6000);
    ar_handshake;
    for (int b = 0; b < 4; b++) begin
      rvalid_i = 1'b1;
      rdata_i = 64'hD0 + 64'(b);
      rlast_i = (b == 3);
      flush_i = (b == 2);
      #1;
      checks++; if (wr_en_o !== (b < 2)) begin errors++; $display("FAIL fs_wr_en beat %0d got %b exp %b", b, wr_en_o, b < 2); end
      checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL fs_rready beat %0d got %b exp 1", b, rready_o); end
      @(negedge axi_clk);
    end
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    flush_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL fs_req_ready got %b exp 1", req_ready_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL fs_proto_err got %b exp 0", proto_err_o); end
  endtask

  task automatic test_error;
    logic [1:0] resp [3] = '{2'b00, 2'b10, 2'b00};
    issue(64'h8000);
    ar_handshake;
    for (int b = 0; b < 3; b++) begin
      rvalid_i = 1'b1;
      rdata_i = 64'hE0 + 64'(b);
      rresp_i = resp[b];
      rlast_i = (b == 2);
      #1;
      checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL err_wr_en beat %0d got %b exp 1", b, wr_en_o); end
      checks++; if (wr_err_o !== (b == 1)) begin errors++; $display("FAIL err_wr_err beat %0d got %b exp %b", b, wr_err_o, b == 1); end
      checks++; if (wr_last_o !== (b == 2)) begin errors++; $display("FAIL err_wr_last beat %0d got %b exp %b", b, wr_last_o, b == 2); end
      @(negedge axi_clk);
    end
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    rresp_i = 2'b00;
    #1;
    checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL err_proto_err got %b exp 1", proto_err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL err_idle got %b exp 0", busy_o); end
    repeat (3) @(negedge axi_clk);
    #1;
    checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", proto_err_o); end
  endtask

  task automatic test_midreset;
    issue(64'hA000);
    ar_handshake;
    rvalid_i = 1'b1;
    rdata_i = 64'hF0;
    #1;
    checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL mr_beat0 got %b exp 1", wr_en_o); end
    @(negedge axi_clk);
    rdata_i = 64'hF1;
    axi_resetn = 1'b0;
    @(negedge axi_clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", busy_o); end
    checks++; if (rready_o !== 1'b0) begin errors++; $display("FAIL mr_rready got %b exp 0", rready_o); end
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL mr_wr_en got %b exp 0", wr_en_o); end
    checks++; if (wr_data_o !== 64'h0) begin errors++; $display("FAIL mr_wr_data got %h exp 0", wr_data_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL mr_req_ready got %b exp 0", req_ready_o); end
    checks++; if (araddr_o !== 64'h0) begin errors++; $display("FAIL mr_araddr got %h exp 0", araddr_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL mr_proto_err got %b exp 0", proto_err_o); end
    axi_resetn = 1'b1;
    rvalid_i = 1'b0;
    @(negedge axi_clk);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mr_release_req_ready got %b exp 1", req_ready_o); end
  endtask

  initial begin
    @(negedge axi_clk);
    test_reset;
    test_basic;
    @(negedge axi_clk);
    test_backpressure;
    @(negedge axi_clk);
    test_flush_addr;
    @(negedge axi_clk);
    test_flush_stream;
    @(negedge axi_clk);
    test_error;
    @(negedge axi_clk);
    test_midreset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
